// File: rtl/axi_wrr_arbiter.sv
// Weighted round-robin arbiter with per-requester credits and a
// registered ready/valid grant interface.
//
// state | meaning
// IDLE  | no grant outstanding; arbitrate, refill credits or reload config
// GRANT | grant registered and held until gnt_ready
module axi_wrr_arbiter #(
    parameter int REQ_NUM  = 8,
    parameter int WEIGHT_W = 4,
    localparam int ID_W    = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [REQ_NUM-1:0]           req,
    input  logic [REQ_NUM*WEIGHT_W-1:0]  weight_cfg,
    input  logic                         cfg_load,
    input  logic                         gnt_ready,
    output logic                         gnt_valid,
    output logic [REQ_NUM-1:0]           gnt,
    output logic [ID_W-1:0]              gnt_id,
    output logic                         round_done
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                state_q, state_d;
    logic [WEIGHT_W-1:0]   credit_q [REQ_NUM];
    logic [WEIGHT_W-1:0]   credit_d [REQ_NUM];
    logic [ID_W-1:0]       ptr_q, ptr_d;
    logic                  gnt_valid_q, gnt_valid_d;
    logic [REQ_NUM-1:0]    gnt_q, gnt_d;
    logic [ID_W-1:0]       gnt_id_q, gnt_id_d;
    logic                  round_done_q, round_done_d;

    logic [WEIGHT_W-1:0]   weight [REQ_NUM];
    logic [REQ_NUM-1:0]    eligible;
    logic [REQ_NUM-1:0]    refillable;
    logic                  sel_found;
    logic [ID_W-1:0]       sel_id;
    logic [WEIGHT_W-1:0]   credit_dec;
    logic [ID_W-1:0]       gnt_id_inc;

    // Unpack weights and classify each requester.
    always_comb begin
        for (int i = 0; i < REQ_NUM; i++) begin
            weight[i]     = weight_cfg[i*WEIGHT_W +: WEIGHT_W];
            eligible[i]   = req[i] & (credit_q[i] != '0);
            refillable[i] = req[i] & (weight[i] != '0);
        end
    end

    // First eligible requester scanning upward from ptr, wrapping.
    always_comb begin
        int idx;
        sel_found = 1'b0;
        sel_id    = '0;
        idx       = 0;
        for (int k = 0; k < REQ_NUM; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= REQ_NUM) idx = idx - REQ_NUM;
            if (!sel_found && eligible[idx]) begin
                sel_found = 1'b1;
                sel_id    = ID_W'(idx);
            end
        end
    end

    assign credit_dec = credit_q[gnt_id_q] - WEIGHT_W'(1);
    assign gnt_id_inc = (gnt_id_q == ID_W'(REQ_NUM-1)) ? '0 : gnt_id_q + ID_W'(1);

    // State register and all datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            gnt_valid_q  <= 1'b0;
            gnt_q        <= '0;
            gnt_id_q     <= '0;
            round_done_q <= 1'b0;
            for (int i = 0; i < REQ_NUM; i++) credit_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            gnt_valid_q  <= gnt_valid_d;
            gnt_q        <= gnt_d;
            gnt_id_q     <= gnt_id_d;
            round_done_q <= round_done_d;
            for (int i = 0; i < REQ_NUM; i++) credit_q[i] <= credit_d[i];
        end
    end

    // Next-state: a reload never issues a grant in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!cfg_load && sel_found) state_d = GRANT;
            GRANT:   if (gnt_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Credits, pointer and grant registers; a reload overrides the decrement.
    always_comb begin
        for (int i = 0; i < REQ_NUM; i++) credit_d[i] = credit_q[i];
        ptr_d        = ptr_q;
        gnt_valid_d  = gnt_valid_q;
        gnt_d        = gnt_q;
        gnt_id_d     = gnt_id_q;
        round_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_load) begin
                    for (int i = 0; i < REQ_NUM; i++) credit_d[i] = weight[i];
                    ptr_d        = '0;
                    round_done_d = 1'b1;
                end else if (sel_found) begin
                    gnt_valid_d    = 1'b1;
                    gnt_d          = '0;
                    gnt_d[sel_id]  = 1'b1;
                    gnt_id_d       = sel_id;
                end else if (refillable != '0) begin
                    for (int i = 0; i < REQ_NUM; i++) credit_d[i] = weight[i];
                    round_done_d = 1'b1;
                end
            end
            GRANT: begin
                if (gnt_ready) begin
                    credit_d[gnt_id_q] = credit_dec;
                    ptr_d       = (credit_dec != '0) ? gnt_id_q : gnt_id_inc;
                    gnt_valid_d = 1'b0;
                    gnt_d       = '0;
                    gnt_id_d    = '0;
                end
                if (cfg_load) begin
                    for (int i = 0; i < REQ_NUM; i++) credit_d[i] = weight[i];
                    ptr_d        = '0;
                    round_done_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Outputs come straight from registers.
    always_comb begin
        gnt_valid  = gnt_valid_q;
        gnt        = gnt_q;
        gnt_id     = gnt_id_q;
        round_done = round_done_q;
    end

endmodule

// File: tb/tb_axi_wrr_arbiter.sv
// Directed bench for axi_wrr_arbiter with REQ_NUM=4, WEIGHT_W=3.
module tb_axi_wrr_arbiter;

    localparam int REQ_NUM  = 4;
    localparam int WEIGHT_W = 3;
    localparam int ID_W     = 2;
    localparam int RD       = 9;   // event code for a round_done pulse

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic [REQ_NUM-1:0]          req = '0;
    logic [REQ_NUM*WEIGHT_W-1:0] weight_cfg = '0;
    logic                        cfg_load = 1'b0;
    logic                        gnt_ready = 1'b0;
    logic                        gnt_valid;
    logic [REQ_NUM-1:0]          gnt;
    logic [ID_W-1:0]             gnt_id;
    logic                        round_done;

    int n_checks = 0;
    int n_fail   = 0;
    int ev[$];
    int e[$];

    // weights {r3,r2,r1,r0}
    localparam logic [11:0] W_BASE = {3'd0, 3'd2, 3'd1, 3'd3};
    localparam logic [11:0] W_ONES = {3'd0, 3'd1, 3'd1, 3'd1};

    axi_wrr_arbiter #(.REQ_NUM(REQ_NUM), .WEIGHT_W(WEIGHT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .weight_cfg (weight_cfg),
        .cfg_load   (cfg_load),
        .gnt_ready  (gnt_ready),
        .gnt_valid  (gnt_valid),
        .gnt        (gnt),
        .gnt_id     (gnt_id),
        .round_done (round_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        cfg_load = 1'b0;
        #1;
        chk("rst_gnt_valid", gnt_valid, 0);
        chk("rst_gnt", gnt, 0);
        chk("rst_gnt_id", gnt_id, 0);
        chk("rst_round_done", round_done, 0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_gnt(input int budget);
        int n;
        n = 0;
        while (!gnt_valid && n < budget) begin
            tick();
            n++;
        end
        if (!gnt_valid) chk("gnt_timeout", 0, 1);
    endtask

    task automatic collect(input int n, input int budget);
        int c;
        ev.delete();
        c = 0;
        while (ev.size() < n && c < budget) begin
            tick();
            c++;
            if (round_done) ev.push_back(RD);
            if (gnt_valid) ev.push_back(int'(gnt_id));
        end
    endtask

    task automatic cmp_seq(input string tag);
        chk({tag, "_len"}, ev.size(), e.size());
        for (int i = 0; i < e.size(); i++)
            if (i < ev.size()) chk(tag, ev[i], e[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        // Full request, always ready: two complete rounds, r3 never served.
        weight_cfg = W_BASE; req = 4'b1111; gnt_ready = 1'b1;
        do_reset();
        collect(14, 60);
        e = '{RD,0,0,0,1,2,2,RD,0,0,0,1,2,2};
        cmp_seq("wrr_seq");

        // Single requester stalled by downstream for 5 cycles.
        weight_cfg = W_BASE; req = 4'b0001; gnt_ready = 1'b0;
        do_reset();
        wait_gnt(10);
        for (int i = 0; i < 5; i++) begin
            chk("hold_gnt", gnt, 4'b0001);
            chk("hold_id", gnt_id, 0);
            chk("hold_credit", dut.credit_q[0], 3);
            tick();
        end
        gnt_ready = 1'b1;
        tick();
        chk("accept_valid", gnt_valid, 0);
        chk("accept_credit", dut.credit_q[0], 2);

        // Only r2 requests: round every two grants.
        weight_cfg = W_BASE; req = 4'b0100; gnt_ready = 1'b1;
        do_reset();
        collect(6, 30);
        e = '{RD,2,2,RD,2,2};
        cmp_seq("r2_seq");

        // Reconfiguration in the middle of a round.
        weight_cfg = W_BASE; req = 4'b1111; gnt_ready = 1'b1;
        do_reset();
        collect(3, 20);
        e = '{RD,0,0};
        cmp_seq("pre_cfg");
        weight_cfg = W_ONES;
        cfg_load   = 1'b1;
        tick();
        cfg_load = 1'b0;
        chk("cfg_round_done", round_done, 1);
        chk("cfg_no_gnt", gnt_valid, 0);
        chk("cfg_ptr", dut.ptr_q, 0);
        collect(4, 20);
        e = '{0,1,2,RD};
        cmp_seq("post_cfg");

        // Asynchronous reset while a grant is stalled.
        weight_cfg = W_BASE; req = 4'b0001; gnt_ready = 1'b0;
        do_reset();
        wait_gnt(10);
        chk("pre_rst_valid", gnt_valid, 1);
        rst = 1'b1;
        #1;
        chk("async_rst_valid", gnt_valid, 0);
        chk("async_rst_gnt", gnt, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("rel_refill", round_done, 1);
        chk("rel_no_gnt", gnt_valid, 0);
        chk("rel_credit", dut.credit_q[0], 3);
        tick();
        chk("rel_first_gnt", gnt_valid, 1);
        chk("rel_first_id", gnt_id, 0);

        // Granted requester drops its request before acceptance.
        weight_cfg = W_BASE; req = 4'b0011; gnt_ready = 1'b0;
        do_reset();
        wait_gnt(10);
        req = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("drop_hold_gnt", gnt, 4'b0001);
            chk("drop_hold_valid", gnt_valid, 1);
        end
        gnt_ready = 1'b1;
        tick();
        chk("drop_accept_valid", gnt_valid, 0);
        chk("drop_credit", dut.credit_q[0], 2);
        tick();
        chk("drop_next_id", gnt_id, 1);
        chk("drop_next_valid", gnt_valid, 1);

        // Only a zero-weight requester: nothing happens.
        weight_cfg = W_BASE; req = 4'b1000; gnt_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("zw_round_done", round_done, 0);
            chk("zw_gnt_valid", gnt_valid, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
